// File: rtl/systolic_sched_if.sv
// Host-side bundle of the systolic sequencer:
// operand write port, run control and result stream.
interface systolic_sched_if #(
   parameter int DW = 32,
   parameter int RW = 64
);
   logic          ld_valid;
   logic          ld_ready;
   logic          ld_sel;
   logic [3:0]    ld_addr;
   logic [DW-1:0] ld_data;
   logic          start;
   logic          busy;
   logic          done;
   logic          res_valid;
   logic          res_ready;
   logic [3:0]    res_idx;
   logic [RW-1:0] res_data;

   modport master (
      output ld_valid, ld_sel, ld_addr, ld_data,
      output start, res_ready,
      input  ld_ready, busy, done,
      input  res_valid, res_idx, res_data
   );

   modport slave (
      input  ld_valid, ld_sel, ld_addr, ld_data,
      input  start, res_ready,
      output ld_ready, busy, done,
      output res_valid, res_idx, res_data
   );
endinterface

// File: rtl/systolic_sched.sv
// Sequencer for the 4x4 systolic array: buffers A/B, clears,
// feeds skewed operands for one run, then streams 16 results.
module systolic_sched #(
   parameter int DW = 32,
   parameter int RW = 64,
   parameter int N  = 4
) (
   input  logic                clk,
   input  logic                rst,
   systolic_sched_if.slave     host,
   output logic                sa_clr,
   output logic                sa_cs,
   output logic [4*DW-1:0]     sa_west,
   output logic [4*DW-1:0]     sa_north,
   input  logic [16*RW-1:0]    sa_result
);

   localparam int FEED_CYC = 3*N - 2;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [3:0]    t;
   logic [3:0]    t_nx;
   logic [3:0]    k;
   logic [3:0]    k_nx;
   logic          done_q;
   logic          done_nx;
   logic          fload;
   logic [3:0]    ft;
   logic [DW-1:0] a_buf [16];
   logic [DW-1:0] b_buf [16];
   logic [DW-1:0] w_q   [4];
   logic [DW-1:0] n_q   [4];
   logic [DW-1:0] w_nx  [4];
   logic [DW-1:0] n_nx  [4];

   always_comb begin
      state_nx = state;
      t_nx     = t;
      k_nx     = k;
      done_nx  = 1'b0;
      fload    = 1'b0;
      ft       = t;
      unique case (state)
         IDLE: begin
            if (host.start) state_nx = CLEAR;
         end
         CLEAR: begin
            state_nx = FEED;
            t_nx     = 4'd0;
            fload    = 1'b1;
            ft       = 4'd0;
         end
         FEED: begin
            if (t == 4'(FEED_CYC-1)) begin
               state_nx = DRAIN;
               t_nx     = 4'd0;
               k_nx     = 4'd0;
            end else begin
               t_nx  = t + 4'd1;
               fload = 1'b1;
               ft    = t + 4'd1;
            end
         end
         DRAIN: begin
            if (host.res_ready) begin
               if (k == 4'd15) begin
                  state_nx = IDLE;
                  k_nx     = 4'd0;
                  done_nx  = 1'b1;
               end else begin
                  k_nx = k + 4'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Skew: row i / column j lag by i / j cycles.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_nx[i] = '0;
         n_nx[i] = '0;
         if (fload && ft >= 4'(i) && (ft - 4'(i)) < 4'd4) begin
            w_nx[i] = a_buf[{2'(i), 2'(ft - 4'(i))}];
            n_nx[i] = b_buf[{2'(ft - 4'(i)), 2'(i)}];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         t      <= 4'd0;
         k      <= 4'd0;
         done_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            w_q[i] <= '0;
            n_q[i] <= '0;
         end
         for (int q = 0; q < 16; q++) begin
            a_buf[q] <= '0;
            b_buf[q] <= '0;
         end
      end else begin
         state  <= state_nx;
         t      <= t_nx;
         k      <= k_nx;
         done_q <= done_nx;
         for (int i = 0; i < 4; i++) begin
            w_q[i] <= w_nx[i];
            n_q[i] <= n_nx[i];
         end
         if (state == IDLE && host.ld_valid) begin
            if (host.ld_sel) b_buf[host.ld_addr] <= host.ld_data;
            else             a_buf[host.ld_addr] <= host.ld_data;
         end
      end
   end

   always_comb begin
      sa_west  = '0;
      sa_north = '0;
      for (int i = 0; i < 4; i++) begin
         sa_west[i*DW +: DW]  = w_q[i];
         sa_north[i*DW +: DW] = n_q[i];
      end
   end

   assign sa_clr         = (state == CLEAR);
   assign sa_cs          = (state == FEED);
   assign host.ld_ready  = (state == IDLE);
   assign host.busy      = (state != IDLE);
   assign host.done      = done_q;
   assign host.res_valid = (state == DRAIN);
   assign host.res_idx   = k;
   assign host.res_data  = host.res_valid
                         ? sa_result[32'(k)*RW +: RW]
                         : '0;

endmodule

// File: tb/tb_systolic_sched.sv
// Bench for systolic_sched with a behavioural 4x4 MAC array
// behind it; table-driven runs plus directed corner sequences.
module tb_systolic_sched;
   localparam int DW = 32;
   localparam int RW = 64;

   logic              clk;
   logic              rst;
   logic              sa_clr;
   logic              sa_cs;
   logic [4*DW-1:0]   sa_west;
   logic [4*DW-1:0]   sa_north;
   logic [16*RW-1:0]  sa_result;

   systolic_sched_if #(.DW(DW), .RW(RW)) h ();

   systolic_sched #(.DW(DW), .RW(RW), .N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .host      (h),
      .sa_clr    (sa_clr),
      .sa_cs     (sa_cs),
      .sa_west   (sa_west),
      .sa_north  (sa_north),
      .sa_result (sa_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Array model: PE(i,j) passes west east and north south.
   logic [DW-1:0] pw  [16];
   logic [DW-1:0] pn  [16];
   logic [DW-1:0] win [16];
   logic [DW-1:0] nin [16];
   logic [RW-1:0] acc [16];

   always_comb begin
      for (int q = 0; q < 16; q++) begin
         if (q % 4 == 0) win[q] = sa_west[(q/4)*DW +: DW];
         else            win[q] = pw[(q+15)%16];
         if (q < 4)      nin[q] = sa_north[q*DW +: DW];
         else            nin[q] = pn[(q+12)%16];
      end
   end

   always @(posedge clk) begin
      if (rst || sa_clr) begin
         for (int q = 0; q < 16; q++) begin
            acc[q] <= '0;
            pw[q]  <= '0;
            pn[q]  <= '0;
         end
      end else if (sa_cs) begin
         for (int q = 0; q < 16; q++) begin
            acc[q] <= acc[q] + RW'(win[q]) * RW'(nin[q]);
            pw[q]  <= win[q];
            pn[q]  <= nin[q];
         end
      end
   end

   always_comb begin
      sa_result = '0;
      for (int q = 0; q < 16; q++)
         sa_result[q*RW +: RW] = acc[q];
   end

   int            n_chk;
   int            n_fail;
   logic [DW-1:0] sa [16];
   logic [DW-1:0] sb [16];
   logic [RW-1:0] got [16];
   logic [RW-1:0] keep [16];
   int            dcyc;

   typedef struct {
      int            am;
      int            bm;
      int            rpat;
      logic [RW-1:0] exp [16];
   } vec_t;

   vec_t tv [3];

   task automatic chk(input string nm,
                      input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] fill_val(input int m, input int q);
      case (m)
         0:       return DW'(q + 1);
         1:       return (q % 5 == 0) ? DW'(1) : DW'(0);
         2:       return 32'hFFFF_FFFF;
         default: return DW'(2);
      endcase
   endfunction

   function automatic logic [RW-1:0] cref(input int q);
      logic [RW-1:0] s;
      s = '0;
      for (int m = 0; m < 4; m++)
         s = s + RW'(sa[(q/4)*4+m]) * RW'(sb[m*4+(q%4)]);
      return s;
   endfunction

   task automatic load(input logic sel, input int addr,
                       input logic [DW-1:0] d);
      h.ld_valid = 1'b1;
      h.ld_sel   = sel;
      h.ld_addr  = 4'(addr);
      h.ld_data  = d;
      @(posedge clk); #1;
      h.ld_valid = 1'b0;
      if (sel) sb[addr] = d;
      else     sa[addr] = d;
   endtask

   task automatic run(input int rpat, input bit spur, input bit bwr,
                      input bit swr, input int swr_addr,
                      input logic [DW-1:0] swr_data);
      int            cyc;
      int            beats;
      int            fb;
      bit            hold;
      logic [3:0]    hidx;
      logic [RW-1:0] hdat;
      beats = 0;
      fb    = -1;
      hold  = 1'b0;
      hidx  = '0;
      hdat  = '0;
      h.start = 1'b1;
      if (swr) begin
         h.ld_valid = 1'b1;
         h.ld_sel   = 1'b1;
         h.ld_addr  = 4'(swr_addr);
         h.ld_data  = swr_data;
      end
      @(posedge clk); #1;
      h.start    = 1'b0;
      h.ld_valid = 1'b0;
      cyc = 1;
      while (beats < 16 && cyc < 300) begin
         h.start     = spur && (cyc == 5 || cyc == 14);
         h.ld_valid  = bwr && (cyc == 4);
         h.ld_sel    = 1'b0;
         h.ld_addr   = 4'd0;
         h.ld_data   = 32'd99;
         h.res_ready = (rpat == 0) ? 1'b1 : (cyc % 3 == 0);
         if (cyc == 1) begin
            chk("clear_clr", sa_clr, 1);
            chk("clear_cs", sa_cs, 0);
         end
         if (cyc == 2) begin
            chk("feed0_cs", sa_cs, 1);
            chk("feed0_west0", sa_west[0 +: DW], sa[0]);
            chk("feed0_north0", sa_north[0 +: DW], sb[0]);
            chk("feed0_west1", sa_west[DW +: DW], 0);
         end
         if (cyc == 4 && bwr) chk("busy_ld_ready", h.ld_ready, 0);
         if (cyc == 8) begin
            chk("feed6_west3", sa_west[3*DW +: DW], sa[15]);
            chk("feed6_north3", sa_north[3*DW +: DW], sb[15]);
         end
         if (cyc == 12) chk("drain_cs", sa_cs, 0);
         if (hold) begin
            chk("hold_idx", h.res_idx, hidx);
            chk("hold_data", h.res_data, hdat);
         end
         hold = 1'b0;
         if (h.res_valid) begin
            if (h.res_ready) begin
               if (beats == 0) fb = cyc;
               chk("beat_idx", h.res_idx, beats);
               got[beats] = h.res_data;
               beats++;
            end else begin
               hold = 1'b1;
               hidx = h.res_idx;
               hdat = h.res_data;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      h.res_ready = 1'b0;
      h.start     = 1'b0;
      h.ld_valid  = 1'b0;
      chk("beat_count", beats, 16);
      chk("done_pulse", h.done, 1);
      chk("busy_after", h.busy, 0);
      if (rpat == 0) begin
         chk("first_beat_cyc", fb, 12);
         chk("done_cyc", cyc, 28);
      end
      dcyc = cyc;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      h.ld_valid  = 1'b0;
      h.ld_sel    = 1'b0;
      h.ld_addr   = 4'd0;
      h.ld_data   = '0;
      h.start     = 1'b0;
      h.res_ready = 1'b0;
      for (int q = 0; q < 16; q++) begin
         sa[q] = '0;
         sb[q] = '0;
      end

      tv[0].am = 0; tv[0].bm = 1; tv[0].rpat = 0;
      tv[1].am = 2; tv[1].bm = 2; tv[1].rpat = 0;
      tv[2].am = 3; tv[2].bm = 3; tv[2].rpat = 1;
      for (int q = 0; q < 16; q++) begin
         tv[0].exp[q] = RW'(q + 1);
         tv[1].exp[q] = 64'hFFFF_FFF8_0000_0004;
         tv[2].exp[q] = 64'd16;
      end

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ld_ready", h.ld_ready, 1);
      chk("rst_busy", h.busy, 0);
      chk("rst_done", h.done, 0);
      chk("rst_cs", sa_cs, 0);
      chk("rst_clr", sa_clr, 0);
      chk("rst_res_valid", h.res_valid, 0);
      chk("rst_res_idx", h.res_idx, 0);
      chk("rst_west", sa_west[63:0], 0);

      for (int v = 0; v < 3; v++) begin
         for (int q = 0; q < 16; q++) begin
            load(1'b0, q, fill_val(tv[v].am, q));
            load(1'b1, q, fill_val(tv[v].bm, q));
         end
         run(tv[v].rpat, 1'b0, 1'b0, 1'b0, 0, '0);
         for (int q = 0; q < 16; q++)
            chk($sformatf("vec%0d_res%0d", v, q), got[q], tv[v].exp[q]);
      end

      // Back-to-back runs with spurious starts while busy
      for (int q = 0; q < 16; q++) begin
         load(1'b0, q, fill_val(0, q));
         load(1'b1, q, fill_val(1, q));
      end
      run(0, 1'b1, 1'b0, 1'b0, 0, '0);
      for (int q = 0; q < 16; q++) begin
         keep[q] = got[q];
         chk("b2b_first", got[q], cref(q));
      end
      run(0, 1'b1, 1'b0, 1'b0, 0, '0);
      for (int q = 0; q < 16; q++) begin
         chk("b2b_second", got[q], keep[q]);
         chk("b2b_hand", got[q], RW'(q + 1));
      end
      @(posedge clk); #1;
      chk("b2b_no_queue", h.busy, 0);

      // Reset in the middle of FEED
      h.start = 1'b1;
      @(posedge clk); #1;
      h.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("t5_cs_before", sa_cs, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_busy", h.busy, 0);
      chk("t5_cs", sa_cs, 0);
      chk("t5_ld_ready", h.ld_ready, 1);
      chk("t5_west", sa_west[63:0], 0);
      chk("t5_res_valid", h.res_valid, 0);
      chk("t5_done", h.done, 0);
      for (int q = 0; q < 16; q++) begin
         sa[q] = '0;
         sb[q] = '0;
      end
      run(0, 1'b0, 1'b0, 1'b0, 0, '0);
      for (int q = 0; q < 16; q++)
         chk("t5_cleared", got[q], 0);
      for (int d = 0; d < 4; d++) begin
         load(1'b0, d*5, 32'd1);
         load(1'b1, d*5, 32'd1);
      end
      run(0, 1'b0, 1'b0, 1'b0, 0, '0);
      for (int q = 0; q < 16; q++) begin
         chk("t5_ident", got[q], cref(q));
         chk("t5_ident_hand", got[q], (q % 5 == 0) ? 64'd1 : 64'd0);
      end

      // Dropped write while busy, then write alongside start
      run(0, 1'b0, 1'b1, 1'b0, 0, '0);
      for (int q = 0; q < 16; q++)
         chk("t6_run1", got[q], cref(q));
      sb[5] = 32'd7;
      run(0, 1'b0, 1'b0, 1'b1, 5, 32'd7);
      for (int q = 0; q < 16; q++)
         chk("t6_run2", got[q], cref(q));
      chk("t6_dropped", got[0], 1);
      chk("t6_same_cycle", got[5], 7);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
